sdram_arb4: RTL and testbench
=============================

SDRAM_ARB4 -- requirements
Module: sdram_arb4

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, number of consecutive port-0 grants after which a waiting port 1-3 is served.
REQ-002 Parameter: RD_DEPTH, default 4 (power of 2), maximum number of accepted reads awaiting c_ack.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 p_addr  in  4x32  per-port byte address; port i occupies bits [32i+31:32i].
REQ-006 p_wdata  in  4x32  per-port write data.
REQ-007 p_rd  in  4  per-port read request.
REQ-008 p_wr  in  4x4  per-port byte-enable write request; any set bit means a write request.
REQ-009 p_accept  out  4  per-port request-taken strobe.
REQ-010 p_ack  out  4  per-port read-data-valid strobe.
REQ-011 p_rdata  out  32  c_rdata broadcast to all ports; valid only for the port whose p_ack is high.
REQ-012 c_addr, c_wdata  out  32 each  address and write data to the sdram core.
REQ-013 c_rd  out  1; c_wr  out  4  read request and byte-enable write request to the sdram core.
REQ-014 c_accept, c_ack  in  1 each; c_rdata  in  32  core-side handshake signals and read data.
REQ-015 ack_err  out  1  sticky flag: c_ack arrived with no read outstanding.

Function
REQ-016 A port is requesting when p_rd[i] is set or p_wr[i] is nonzero; a port shall hold its request stable until p_accept[i].
REQ-017 Two states: IDLE (all c_* outputs 0) and GRANT (c_* outputs driven from the granted port g).
REQ-018 In IDLE with any request pending: register winner g and move to GRANT on the next edge (1 cycle arbitration latency).
REQ-019 Priority: port 0 wins over ports 1-3; among ports 1-3, round-robin starting after the last-granted port of 1-3; the pointer resets to port 1.
REQ-020 In GRANT: p_accept[g] = c_accept, combinationally; all other p_accept bits are 0.
REQ-021 A new request never preempts GRANT, including a port-0 request.
REQ-022 On an edge with c_accept high: return to IDLE, giving one bubble cycle between back-to-back grants; if the accepted request was a read, push g into the tag FIFO.
REQ-023 If port g deasserts its request while in GRANT without c_accept (protocol violation): return to IDLE on the next edge; no push.
REQ-024 Tag FIFO: depth RD_DEPTH.
REQ-025 When the FIFO is full, a pending read loses arbitration and is not granted; writes still arbitrate normally; a full FIFO blocks reads even in a cycle where c_ack pops.
REQ-026 On c_ack with FIFO nonempty: p_ack[head] = 1 in the same cycle, and the head is popped at the edge.
REQ-027 A push and a pop in the same edge are both performed, and the count is unchanged.
REQ-028 On c_ack with FIFO empty: no p_ack; ack_err sets at the edge and stays set until reset.
REQ-029 Write acks: the core does not ack writes; completion of a write is p_accept only.

Reset
REQ-030 While rst_n is low: state=IDLE, grant=0, RR pointer=port 1, FIFO empty, starvation counter=0, ack_err=0.
REQ-031 Outputs during reset: c_rd=0, c_wr=0, c_addr=0, c_wdata=0, p_accept=0, p_ack=0.
REQ-032 Reset asserted mid-transaction discards the outstanding read tags; acks arriving after reset set ack_err.

Configuration
REQ-033 Macro SDRAM_ARB4_STARVE_EN defined: a counter increments on each port-0 grant made while any of ports 1-3 is requesting, and clears on any port 1-3 grant.
REQ-034 When that counter reaches STARVE_LIMIT, the next arbitration skips port 0 and grants the round-robin winner.
REQ-035 Macro undefined: strict port-0 priority; no counter logic is instantiated.

Verification
REQ-036 Single write: port 2 requests p_wr=4'hF, addr 0x100, data 0xDEADBEEF -> c_wr=4'hF one cycle later; c_addr/c_wdata match; p_accept[2] coincides with c_accept.
REQ-037 Contention: ports 0, 1, 3 request together with a core accepting immediately -> grant order 0, 1, 3, each separated by one idle cycle.
REQ-038 Read routing: port 1 reads 0x40, then port 3 reads 0x80; core acks with 0x11 then 0x33 -> p_ack[1] carries 0x11, then p_ack[3] carries 0x33.
REQ-039 FIFO full: RD_DEPTH=4 reads outstanding, a fifth read and a write are pending -> the write is granted and the read waits until the first c_ack.
REQ-040 Starvation with SDRAM_ARB4_STARVE_EN, STARVE_LIMIT=8: port 0 requests continuously and port 2 waits -> port 2 is granted after exactly 8 port-0 grants; without the macro, port 2 is never granted.
REQ-041 Errors: c_ack pulsed with the FIFO empty -> ack_err=1 and no p_ack; rst_n pulsed low mid-GRANT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sdram_arb4.sv
// Four-port arbiter in front of a single SDRAM core: port 0 priority, round-robin on ports 1-3,
// read-tag FIFO for routing c_ack. Optional starvation guard: define SDRAM_ARB4_STARVE_EN.
module sdram_arb4 #(
  parameter int STARVE_LIMIT = 8,
  parameter int RD_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] p_addr,
  input  logic [127:0] p_wdata,
  input  logic [3:0]   p_rd,
  input  logic [15:0]  p_wr,
  output logic [3:0]   p_accept,
  output logic [3:0]   p_ack,
  output logic [31:0]  p_rdata,
  output logic [31:0]  c_addr,
  output logic [31:0]  c_wdata,
  output logic         c_rd,
  output logic [3:0]   c_wr,
  input  logic         c_accept,
  input  logic         c_ack,
  input  logic [31:0]  c_rdata,
  output logic         ack_err
);
  localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int CW = $clog2(RD_DEPTH + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_grant;
  logic [1:0]    r_rr_ptr;
  logic [1:0]    r_tags [RD_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ack_err;

  logic [3:0] w_req, w_elig;
  logic       w_full, w_push, w_pop, w_any, w_rr_valid, w_skip0;
  logic [1:0] w_rr_win, w_win;

  // Port visited k steps after ptr within the ring 1 -> 2 -> 3 -> 1.
  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int k);
    int t;
    t = int'(ptr) + k;
    if (t > 3) t = t - 3;
    return t[1:0];
  endfunction

  assign w_full = (r_count == CW'(RD_DEPTH));

  // A read cannot be granted while the tag FIFO has no room for its tag.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_req[i]  = p_rd[i] | (|p_wr[4*i +: 4]);
      w_elig[i] = w_req[i] & ~(p_rd[i] & w_full);
    end
  end

  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_win   = 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!w_rr_valid && w_elig[rr_idx(r_rr_ptr, k)]) begin
        w_rr_valid = 1'b1;
        w_rr_win   = rr_idx(r_rr_ptr, k);
      end
    end
    w_any = |w_elig;
    if (w_elig[0] && !(w_skip0 && w_rr_valid)) w_win = 2'd0;
    else if (w_rr_valid)                       w_win = w_rr_win;
    else                                       w_win = 2'd0;
  end

`ifdef SDRAM_ARB4_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;

  assign w_skip0 = (r_starve_cnt >= SW'(STARVE_LIMIT));

  // Saturates at the limit; any port 1-3 grant restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      if (w_win != 2'd0)                    r_starve_cnt <= '0;
      else if ((|w_req[3:1]) && !w_skip0)   r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end
`else
  assign w_skip0 = 1'b0 & (STARVE_LIMIT != 0);
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_next   = r_state;
    w_push   = 1'b0;
    p_accept = 4'b0;
    c_addr   = 32'b0;
    c_wdata  = 32'b0;
    c_rd     = 1'b0;
    c_wr     = 4'b0;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_GRANT;
      S_GRANT: begin
        c_addr            = p_addr[{r_grant, 5'd0} +: 32];
        c_wdata           = p_wdata[{r_grant, 5'd0} +: 32];
        c_rd              = p_rd[r_grant];
        c_wr              = p_wr[{r_grant, 2'd0} +: 4];
        p_accept[r_grant] = c_accept;
        if (c_accept) begin
          w_next = S_IDLE;
          w_push = p_rd[r_grant];
        end else if (!w_req[r_grant]) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= 2'd0;
      r_rr_ptr <= 2'd1;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge values.
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_win;
        if (w_win != 2'd0) r_rr_ptr <= (w_win == 2'd3) ? 2'd1 : w_win + 2'd1;
      end
    end
  end

  assign w_pop = c_ack & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ack_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (c_ack && r_count == '0) r_ack_err <= 1'b1;
    end
  end

  // NOTE: tag storage is deliberately not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= r_grant;
  end

  assign p_ack   = w_pop ? (4'b0001 << r_tags[r_rd_ptr]) : 4'b0000;
  assign p_rdata = c_rdata;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_sdram_arb4.sv
// Self-checking bench for sdram_arb4: directed scenarios plus randomized traffic against a
// transaction-level model (grant owner, tag queue, round-robin pointer, sticky error).
module tb_sdram_arb4;
  localparam int STARVE_LIMIT = 8;
  localparam int RD_DEPTH     = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] p_addr, p_wdata;
  logic [3:0]   p_rd;
  logic [15:0]  p_wr;
  logic [3:0]   p_accept, p_ack;
  logic [31:0]  p_rdata, c_addr, c_wdata, c_rdata;
  logic         c_rd, c_accept, c_ack, ack_err;
  logic [3:0]   c_wr;

  sdram_arb4 #(.STARVE_LIMIT(STARVE_LIMIT), .RD_DEPTH(RD_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_rd(p_rd), .p_wr(p_wr),
    .p_accept(p_accept), .p_ack(p_ack), .p_rdata(p_rdata),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rd(c_rd), .c_wr(c_wr),
    .c_accept(c_accept), .c_ack(c_ack), .c_rdata(c_rdata), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit         m_busy;
  int         m_g;
  int         m_rr;
  int         m_q[$];
  bit         m_err;
  int         m_starve;
  logic [3:0] m_acc;
  logic [3:0] last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit req(input int i);
    return p_rd[i] || (p_wr[4*i +: 4] != 4'b0);
  endfunction

  task automatic set_req(input int i, input bit rd, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] data);
    p_addr[32*i +: 32]  = addr;
    p_wdata[32*i +: 32] = data;
    p_rd[i]             = rd;
    p_wr[4*i +: 4]      = be;
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_g      = 0;
    m_rr     = 1;
    m_q.delete();
    m_err    = 1'b0;
    m_starve = 0;
    m_acc    = 4'b0;
  endtask

  task automatic check_outputs();
    logic [31:0] e_addr, e_wdata;
    logic        e_rd;
    logic [3:0]  e_wr, e_acc, e_ack;
    e_addr = '0; e_wdata = '0; e_rd = 1'b0; e_wr = '0; e_acc = '0;
    if (m_busy) begin
      e_addr  = p_addr[32*m_g +: 32];
      e_wdata = p_wdata[32*m_g +: 32];
      e_rd    = p_rd[m_g];
      e_wr    = p_wr[4*m_g +: 4];
      e_acc   = c_accept ? 4'(1 << m_g) : 4'b0;
    end
    e_ack = (c_ack && m_q.size() > 0) ? 4'(1 << m_q[0]) : 4'b0;
    check("c_addr", c_addr, e_addr);
    check("c_wdata", c_wdata, e_wdata);
    check("c_rd", {31'b0, c_rd}, {31'b0, e_rd});
    check("c_wr", {28'b0, c_wr}, {28'b0, e_wr});
    check("p_accept", {28'b0, p_accept}, {28'b0, e_acc});
    check("p_ack", {28'b0, p_ack}, {28'b0, e_ack});
    check("p_rdata", p_rdata, c_rdata);
    check("ack_err", {31'b0, ack_err}, {31'b0, m_err});
    m_acc    = e_acc;
    last_acc = p_accept;
  endtask

  // Advance the model across one rising edge using the inputs the DUT will sample there.
  task automatic model_edge();
    bit pop, push, full, rrv, skip;
    bit elig[4];
    int rrw, win, pg, p;
    pop  = c_ack && m_q.size() > 0;
    push = 1'b0;
    pg   = 0;
    if (c_ack && m_q.size() == 0) m_err = 1'b1;
    full = (m_q.size() == RD_DEPTH);
    if (m_busy) begin
      if (c_accept) begin
        m_busy = 1'b0;
        if (p_rd[m_g]) begin push = 1'b1; pg = m_g; end
      end else if (!req(m_g)) begin
        m_busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) elig[i] = req(i) && !(p_rd[i] && full);
      rrv = 1'b0; rrw = 0;
      for (int k = 0; k < 3; k++) begin
        p = ((m_rr - 1 + k) % 3) + 1;
        if (!rrv && elig[p]) begin rrv = 1'b1; rrw = p; end
      end
      skip = 1'b0;
`ifdef SDRAM_ARB4_STARVE_EN
      skip = (m_starve >= STARVE_LIMIT);
`endif
      win = -1;
      if (elig[0] && !(skip && rrv)) win = 0;
      else if (rrv)                  win = rrw;
      if (win >= 0) begin
        m_busy = 1'b1;
        m_g    = win;
        if (win > 0) begin
          m_rr     = (win % 3) + 1;
          m_starve = 0;
        end else if ((req(1) || req(2) || req(3)) && m_starve < STARVE_LIMIT) begin
          m_starve++;
        end
      end
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(pg);
  endtask

  // Check at the falling edge, step the model, then retire accepted requests after the rise.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (m_acc[i]) begin
        p_rd[i]        = 1'b0;
        p_wr[4*i +: 4] = 4'b0;
      end
    end
  endtask

  task automatic reset_checks();
    check("rst_c_rd", {31'b0, c_rd}, 32'd0);
    check("rst_c_wr", {28'b0, c_wr}, 32'd0);
    check("rst_c_addr", c_addr, 32'd0);
    check("rst_c_wdata", c_wdata, 32'd0);
    check("rst_p_accept", {28'b0, p_accept}, 32'd0);
    check("rst_p_ack", {28'b0, p_ack}, 32'd0);
    check("rst_ack_err", {31'b0, ack_err}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_stim(input int ack_pct);
    for (int i = 0; i < 4; i++) begin
      if (!req(i) && $urandom_range(99) < 30) begin
        if ($urandom_range(1) == 1) set_req(i, 1'b1, 4'b0, $urandom, $urandom);
        else set_req(i, 1'b0, 4'($urandom_range(15, 1)), $urandom, $urandom);
      end
    end
    c_accept = ($urandom_range(99) < 60);
    c_ack    = (m_q.size() > 0) && ($urandom_range(99) < ack_pct);
    c_rdata  = $urandom;
  endtask

  int n0;
  bit seen2;

  initial begin
    p_addr = '0; p_wdata = '0; p_rd = '0; p_wr = '0;
    c_rdata = '0; last_acc = '0;
    model_reset();

    // Reset holds every output low even with requests and core strobes active.
    rst_n = 1'b0; p_rd = 4'hF; c_accept = 1'b1; c_ack = 1'b1;
    #12;
    reset_checks();
    p_rd = 4'h0; c_ack = 1'b0; c_accept = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write from port 2.
    set_req(2, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF);
    cycle();
    check("wr_c_wr", {28'b0, c_wr}, 32'hF);
    check("wr_c_addr", c_addr, 32'h100);
    check("wr_c_wdata", c_wdata, 32'hDEADBEEF);
    c_accept = 1'b1;
    #1;
    check("wr_p_accept", {28'b0, p_accept}, 32'b0100);
    cycle();
    c_accept = 1'b0;

    // Read routing: port 1 then port 3, acked in order.
    c_accept = 1'b1;
    set_req(1, 1'b1, 4'b0, 32'h40, 32'h0);
    cycle(); cycle();
    set_req(3, 1'b1, 4'b0, 32'h80, 32'h0);
    cycle(); cycle();
    c_accept = 1'b0;
    cycle();
    c_ack = 1'b1; c_rdata = 32'h11;
    #1;
    check("rd_ack1", {28'b0, p_ack}, 32'b0010);
    check("rd_data1", p_rdata, 32'h11);
    cycle();
    c_rdata = 32'h33;
    #1;
    check("rd_ack3", {28'b0, p_ack}, 32'b1000);
    check("rd_data3", p_rdata, 32'h33);
    cycle();
    c_ack = 1'b0;

    // Stray ack with an empty FIFO.
    c_ack = 1'b1;
    #1;
    check("stray_no_ack", {28'b0, p_ack}, 32'd0);
    cycle();
    c_ack = 1'b0;
    check("stray_err_set", {31'b0, ack_err}, 32'd1);
    cycle();
    check("stray_err_sticky", {31'b0, ack_err}, 32'd1);
    apply_reset();

    // Reset mid-GRANT with a read outstanding; a later ack is then an error.
    c_accept = 1'b1;
    set_req(0, 1'b1, 4'b0, 32'h200, 32'h0);
    cycle(); cycle();
    c_accept = 1'b0;
    set_req(2, 1'b0, 4'h3, 32'h300, 32'h12345678);
    cycle();
    check("mid_grant_c_wr", {28'b0, c_wr}, 32'h3);
    #2;
    c_accept = 1'b1;
    apply_reset();
    c_accept = 1'b0;
    c_ack = 1'b1;
    cycle();
    c_ack = 1'b0;
    check("post_rst_ack_err", {31'b0, ack_err}, 32'd1);
    c_accept = 1'b1;
    cycle(); cycle();
    c_accept = 1'b0;
    apply_reset();

    // Fill the tag FIFO, then a pending read must yield to a pending write.
    c_accept = 1'b1;
    for (int k = 0; k < RD_DEPTH; k++) begin
      set_req(1, 1'b1, 4'b0, 32'h1000 + 32'(k), 32'h0);
      cycle(); cycle();
    end
    set_req(0, 1'b1, 4'b0, 32'h2000, 32'h0);
    set_req(3, 1'b0, 4'hF, 32'h3000, 32'hCAFEF00D);
    cycle(); cycle();
    check("full_write_first", {28'b0, last_acc}, 32'b1000);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("full_read_blocked", {28'b0, last_acc}, 32'd0);
    end
    c_ack = 1'b1; c_rdata = 32'hA5A5A5A5;
    cycle();
    check("full_blocked_on_pop", {28'b0, last_acc}, 32'd0);
    c_ack = 1'b0;
    cycle(); cycle();
    check("full_read_after_ack", {28'b0, last_acc}, 32'b0001);
    c_accept = 1'b0;
    for (int k = 0; k < 10 && m_q.size() > 0; k++) begin
      c_ack = 1'b1;
      cycle();
    end
    c_ack = 1'b0;
    check("fifo_drained", 32'(m_q.size()), 32'd0);

    // Starvation: port 0 requests back to back while port 2 waits.
    apply_reset();
    c_accept = 1'b1;
    set_req(2, 1'b0, 4'hF, 32'h4000, 32'h0);
    n0 = 0; seen2 = 1'b0;
    for (int k = 0; k < 60 && !seen2; k++) begin
      if (!req(0)) set_req(0, 1'b0, 4'h1, $urandom, $urandom);
      cycle();
      if (last_acc[0]) n0++;
      if (last_acc[2]) seen2 = 1'b1;
    end
`ifdef SDRAM_ARB4_STARVE_EN
    check("starve_p2_served", {31'b0, seen2}, 32'd1);
    check("starve_p0_count", 32'(n0), 32'(STARVE_LIMIT));
`else
    check("starve_p2_blocked", {31'b0, seen2}, 32'd0);
    check("starve_p0_busy", {31'b0, (n0 >= 20)}, 32'd1);
`endif
    for (int k = 0; k < 8; k++) cycle();
    c_accept = 1'b0;

    // Randomized traffic: slow acks keep the FIFO near full, fast acks keep it draining.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(499) == 0) begin
          apply_reset();
        end else begin
          rand_stim(ph == 0 ? 10 : 45);
          cycle();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
